// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI master controller and its shifter.
package spi_pkg;

   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;

   typedef enum logic [1:0] {
      WR_ADDR = 2'b00,
      WR_DATA = 2'b01,
      RD_ADDR = 2'b10,
      RD_DATA = 2'b11
   } spi_cmd_e;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      TURN,
      RECV,
      END
   } spi_state_e;

endpackage

// File: rtl/spi_mst_shifter.sv
// TX/RX shift registers and the shared down-counter that times each frame phase.
module spi_mst_shifter
   import spi_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [FRAME_W-1:0] load_word_i,
   input  logic               shift_i,
   input  logic               rx_en_i,
   input  logic               miso_i,
   input  logic               cnt_load_i,
   input  logic [3:0]         cnt_val_i,
   input  logic               cnt_dec_i,
   output logic               mosi_o,
   output logic               cnt_zero_o,
   output logic [DATA_W-1:0]  rx_data_o
);

   logic [FRAME_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0]  rx_q, rx_d;
   logic [3:0]         cnt_q, cnt_d;

   // Zeros shift in behind the frame, so MOSI idles low once the last bit leaves.
   always_comb begin
      tx_d  = tx_q;
      rx_d  = rx_q;
      cnt_d = cnt_q;
      if (load_i) begin
         tx_d = load_word_i;
      end else if (shift_i) begin
         tx_d = {tx_q[FRAME_W-2:0], 1'b0};
      end
      if (rx_en_i) begin
         rx_d = {rx_q[DATA_W-2:0], miso_i};
      end
      if (cnt_load_i) begin
         cnt_d = cnt_val_i;
      end else if (cnt_dec_i) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_q  <= '0;
         rx_q  <= '0;
         cnt_q <= '0;
      end else begin
         tx_q  <= tx_d;
         rx_q  <= rx_d;
         cnt_q <= cnt_d;
      end
   end

   assign mosi_o     = tx_q[FRAME_W-1];
   assign cnt_zero_o = (cnt_q == 4'd0);
   assign rx_data_o  = rx_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator: serialises a 10-bit command MSB-first and collects 8 bits for read-data frames.
// Define SPI_MASTER_START_QUEUE_EN to add a one-deep pending-start slot.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int unsigned TURNAROUND = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [FRAME_W-1:0] data_in,
   output logic [DATA_W-1:0]  data_out,
   output logic               busy,
   output logic               done,
   output logic               SS_n,
   output logic               MOSI,
   input  logic               MISO
);

   spi_state_e          state_q;
   spi_cmd_e            cmd_q;
   logic                busy_q;
   logic                done_q;
   logic                ss_n_q;
   logic [DATA_W-1:0]   data_out_q;

   logic                load;
   logic [FRAME_W-1:0]  next_word;
   logic                shift;
   logic                rx_en;
   logic                cnt_load;
   logic [3:0]          cnt_val;
   logic                cnt_dec;
   logic                cnt_zero;
   logic [DATA_W-1:0]   rx_data;

`ifdef SPI_MASTER_START_QUEUE_EN
   logic                pend_vld_q;
   logic [FRAME_W-1:0]  pend_q;
`endif

   // A new frame is loaded from IDLE, or straight out of END when a start is waiting.
   always_comb begin
      load      = 1'b0;
      next_word = data_in;
      case (state_q)
         IDLE: load = start;
`ifdef SPI_MASTER_START_QUEUE_EN
         END: begin
            if (pend_vld_q) begin
               load      = 1'b1;
               next_word = pend_q;
            end else begin
               load      = start;
            end
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      shift    = (state_q == SEND);
      rx_en    = ((state_q == TURN) && cnt_zero) || ((state_q == RECV) && !cnt_zero);
      cnt_dec  = (state_q == SEND) || (state_q == TURN) || (state_q == RECV);
      cnt_load = 1'b0;
      cnt_val  = 4'(FRAME_W - 1);
      if (load) begin
         cnt_load = 1'b1;
      end else if ((state_q == SEND) && cnt_zero && (cmd_q == RD_DATA)) begin
         cnt_load = 1'b1;
         cnt_val  = 4'(TURNAROUND - 1);
      end else if ((state_q == TURN) && cnt_zero) begin
         cnt_load = 1'b1;
         cnt_val  = 4'(DATA_W - 1);
      end
   end

   spi_mst_shifter u_shifter (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (load),
      .load_word_i (next_word),
      .shift_i     (shift),
      .rx_en_i     (rx_en),
      .miso_i      (MISO),
      .cnt_load_i  (cnt_load),
      .cnt_val_i   (cnt_val),
      .cnt_dec_i   (cnt_dec),
      .mosi_o      (MOSI),
      .cnt_zero_o  (cnt_zero),
      .rx_data_o   (rx_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cmd_q      <= WR_ADDR;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ss_n_q     <= 1'b1;
         data_out_q <= '0;
`ifdef SPI_MASTER_START_QUEUE_EN
         pend_vld_q <= 1'b0;
         pend_q     <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         if (load) begin
            cmd_q <= spi_cmd_e'(next_word[FRAME_W-1:FRAME_W-2]);
         end
         case (state_q)
            IDLE: begin
               if (load) begin
                  state_q <= SEND;
                  busy_q  <= 1'b1;
                  ss_n_q  <= 1'b0;
               end
            end
            SEND: begin
               if (cnt_zero) begin
                  if (cmd_q == RD_DATA) begin
                     state_q <= TURN;
                  end else begin
                     state_q <= END;
                     ss_n_q  <= 1'b1;
                  end
               end
            end
            TURN: begin
               if (cnt_zero) begin
                  state_q <= RECV;
               end
            end
            RECV: begin
               if (cnt_zero) begin
                  state_q <= END;
                  ss_n_q  <= 1'b1;
               end
            end
            END: begin
               done_q <= 1'b1;
               if (cmd_q == RD_DATA) begin
                  data_out_q <= rx_data;
               end
               if (load) begin
                  state_q <= SEND;
                  ss_n_q  <= 1'b0;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               ss_n_q  <= 1'b1;
            end
         endcase
`ifdef SPI_MASTER_START_QUEUE_EN
         // END either drains the slot or finds it empty, so it always leaves empty.
         if (state_q == END) begin
            pend_vld_q <= 1'b0;
         end else if (start && busy_q && !pend_vld_q) begin
            pend_vld_q <= 1'b1;
            pend_q     <= data_in;
         end
`endif
      end
   end

   assign data_out = data_out_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign SS_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Table-driven, scoreboarded bench for spi_master_ctrl with a bus-watching slave model.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

   localparam int T = 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [9:0] data_in;
   logic [7:0] data_out;
   logic       busy;
   logic       done;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;

   spi_master_ctrl #(.TURNAROUND(T)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .data_in  (data_in),
      .data_out (data_out),
      .busy     (busy),
      .done     (done),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] word;
      logic [7:0] dout;
      int         ss_len;
      int         frame_len;
      int         busy_len;
      bit         chk_busy;
   } exp_t;

   typedef struct {
      logic [9:0] word;
      logic [7:0] miso;
      logic [7:0] exp_dout;
   } vec_t;

   exp_t       sb[$];
   exp_t       mon_e;
   vec_t       vecs[8];

   int         checks = 0;
   int         failures = 0;
   int         done_cnt = 0;
   int         ss_len, frame_len, busy_len, gap, last_gap;
   logic [9:0] mosi_w;
   logic       ss_prev;
   logic [7:0] slave_byte;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk_exp(input logic [9:0] w, input logic [7:0] dout, input bit chkb);
      exp_t e;
      bit   rd;
      rd          = (w[9:8] == 2'b11);
      e.word      = w;
      e.dout      = dout;
      e.ss_len    = rd ? 18 + T : 10;
      e.frame_len = rd ? 20 + T : 12;
      e.busy_len  = rd ? 19 + T : 11;
      e.chk_busy  = chkb;
      return e;
   endfunction

   // Monitor + slave: measures each frame on the pins, serves MISO, checks on done.
   always @(negedge clk) begin
      if (!rst_n) begin
         ss_prev   = 1'b1;
         ss_len    = 0;
         frame_len = 0;
         busy_len  = 0;
         gap       = 0;
         mosi_w    = '0;
         MISO      = 1'b0;
      end else begin
         frame_len++;
         if (done) begin
            done_cnt++;
            chk("sb_nonempty_at_done", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
               mon_e = sb.pop_front();
               chk("data_out", data_out, mon_e.dout);
               chk("mosi_bits", mosi_w, mon_e.word);
               chk("ss_low_len", ss_len, mon_e.ss_len);
               chk("frame_len", frame_len, mon_e.frame_len);
               if (mon_e.chk_busy) chk("busy_len", busy_len, mon_e.busy_len);
            end
         end
         if (!SS_n) begin
            if (ss_prev) begin
               last_gap  = gap;
               gap       = 0;
               ss_len    = 0;
               frame_len = 1;
               mosi_w    = '0;
            end
            if (ss_len < 10) mosi_w = {mosi_w[8:0], MOSI};
            if (ss_len >= 9 + T && ss_len <= 16 + T) MISO = slave_byte[16 + T - ss_len];
            else MISO = 1'b0;
            ss_len++;
         end else begin
            gap++;
            MISO = 1'b0;
         end
         ss_prev = SS_n;
         if (busy) busy_len++;
         else busy_len = 0;
      end
   end

   // Called on a falling edge; the start is sampled at the next rising edge (E0).
   task automatic start_frame(input logic [9:0] w, input logic [7:0] mb,
                              input logic [7:0] dout, input bit chkb);
      slave_byte = mb;
      start      = 1'b1;
      data_in    = w;
      sb.push_back(mk_exp(w, dout, chkb));
      @(posedge clk);
      #1;
      start   = 1'b0;
      data_in = 10'($urandom);
      chk("e0_ss_n", SS_n, 0);
      chk("e0_busy", busy, 1);
      chk("e0_mosi", MOSI, w[9]);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", sb.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int base;
      rst_n      = 1'b0;
      start      = 1'b0;
      data_in    = '0;
      slave_byte = '0;
      vecs[0] = '{10'h0A5, 8'h5A, 8'h00};
      vecs[1] = '{10'h300, 8'hC3, 8'hC3};
      vecs[2] = '{10'h1FF, 8'h77, 8'hC3};
      vecs[3] = '{10'h2AA, 8'h12, 8'hC3};
      vecs[4] = '{10'h3FF, 8'h00, 8'h00};
      vecs[5] = '{10'h355, 8'hFF, 8'hFF};
      vecs[6] = '{10'h3AB, 8'h81, 8'h81};
      vecs[7] = '{10'h000, 8'h3E, 8'h81};

      repeat (3) @(negedge clk);
      chk("reset_ss_n", SS_n, 1);
      chk("reset_mosi", MOSI, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_data_out", data_out, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         start_frame(vecs[i].word, vecs[i].miso, vecs[i].exp_dout, 1'b1);
         wait_drain();
         repeat (1 + $urandom_range(0, 2)) @(negedge clk);
      end

      // Starts at E3 and E5 of a running write frame.
      base = done_cnt;
      start_frame(10'h0A5, 8'h00, vecs[7].exp_dout, 1'b1);
`ifdef SPI_MASTER_START_QUEUE_EN
      sb.push_back(mk_exp(10'h1FF, vecs[7].exp_dout, 1'b0));
`endif
      repeat (2) @(posedge clk);
      #1;
      start   = 1'b1;
      data_in = 10'h1FF;
      @(posedge clk);
      #1;
      start   = 1'b0;
      data_in = '0;
      @(posedge clk);
      #1;
      start   = 1'b1;
      data_in = 10'h2AA;
      @(posedge clk);
      #1;
      start   = 1'b0;
      data_in = '0;
      wait_drain();
      repeat (30) @(negedge clk);
`ifdef SPI_MASTER_START_QUEUE_EN
      chk("collision_done_count", done_cnt - base, 2);
      chk("queued_ss_gap", last_gap, 1);
`else
      chk("collision_done_count", done_cnt - base, 1);
`endif

      // Start raised in the done cycle of the previous frame.
      @(negedge clk);
      start_frame(10'h155, 8'h00, vecs[7].exp_dout, 1'b1);
      n = 0;
      while (!done && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_done_seen", done, 1);
      start_frame(10'h3C3, 8'h3C, 8'h3C, 1'b1);
      wait_drain();
      repeat (3) @(negedge clk);

      // Asynchronous reset in the middle of SEND.
      base = done_cnt;
      start_frame(10'h3F0, 8'hAA, 8'h00, 1'b1);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_ss_n", SS_n, 1);
      chk("midrst_mosi", MOSI, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_data_out", data_out, 0);
      chk("midrst_done", done, 0);
      sb.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("midrst_no_done", done_cnt - base, 0);

      start_frame(10'h0A5, 8'h00, 8'h00, 1'b1);
      wait_drain();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
